// File: rtl/axi2lbus_slave_pkg.sv
// axi2lbus_slave_pkg: AXI3 types and bridge FSM states shared by axi2lbus_slave and its sub-module
package axi2lbus_slave_pkg;
  localparam int AXI3_LEN_W = 4;
  typedef logic [2:0] axi3_size_t;
  typedef enum logic [1:0] {BST_FIXED = 2'd0, BST_INCR = 2'd1, BST_WRAP = 2'd2, BST_RSVD = 2'd3} axi3_bst_t;
  typedef enum logic [1:0] {RESP_OKAY = 2'd0, RESP_EXOKAY = 2'd1, RESP_SLVERR = 2'd2, RESP_DECERR = 2'd3} axi3_resp_t;
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_DATA} state_t;
endpackage

// File: rtl/axi2lbus_slave_addr_gen.sv
// axi_burst_addr_gen: next beat address; WRAP/reserved bursts step like INCR but flag an error
module axi_burst_addr_gen
  import axi2lbus_slave_pkg::*;
#(
  parameter int AddrW = 8
) (
  input  logic [AddrW-1:0] i_addr,
  input  axi3_bst_t        i_burst,
  input  logic [AddrW-1:0] i_step,
  output logic [AddrW-1:0] o_addr,
  output logic             o_err
);
  // FIXED holds, everything else advances by the step (wrapping at the address width)
  always_comb begin
    o_addr = (i_burst == BST_FIXED) ? i_addr : i_addr + i_step;
    o_err  = (i_burst != BST_FIXED) && (i_burst != BST_INCR);
  end
endmodule

// File: rtl/axi2lbus_slave.sv
// axi2lbus_slave: AXI3 slave splitting bursts into single-beat lbus accesses; optional lbus timeout via AXI2LBUS_SLAVE_TIMEOUT_EN
module axi2lbus_slave
  import axi2lbus_slave_pkg::*;
#(
  parameter int AddrW = 8,
  parameter int DataW = 32,
  parameter int IdW = 2,
  parameter int AxiIdW = 4,
  parameter logic [IdW-1:0] BusId = '0,
  parameter int TimeoutCyc = 255,
  localparam int StrbW = DataW / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AxiIdW-1:0]     axi_awid,
  input  logic [AddrW-1:0]      axi_awaddr,
  input  logic [AXI3_LEN_W-1:0] axi_awlen,
  input  axi3_size_t            axi_awsize,
  input  axi3_bst_t             axi_awburst,
  input  logic                  axi_awvalid,
  output logic                  axi_awreadyo,
  input  logic [DataW-1:0]      axi_wdata,
  input  logic [StrbW-1:0]      axi_wstrb,
  input  logic                  axi_wlast,
  input  logic                  axi_wvalid,
  output logic                  axi_wreadyo,
  output logic [AxiIdW-1:0]     axi_bido,
  output axi3_resp_t            axi_brespo,
  output logic                  axi_bvalido,
  input  logic                  axi_bready,
  input  logic [AxiIdW-1:0]     axi_arid,
  input  logic [AddrW-1:0]      axi_araddr,
  input  logic [AXI3_LEN_W-1:0] axi_arlen,
  input  axi3_size_t            axi_arsize,
  input  axi3_bst_t             axi_arburst,
  input  logic                  axi_arvalid,
  output logic                  axi_arreadyo,
  output logic [AxiIdW-1:0]     axi_rido,
  output logic [DataW-1:0]      axi_rdatao,
  output axi3_resp_t            axi_rrespo,
  output logic                  axi_rlasto,
  output logic                  axi_rvalido,
  input  logic                  axi_rready,
  output logic                  bus_reqo,
  output logic [IdW-1:0]        bus_ido,
  output logic [StrbW-1:0]      bus_strbo,
  output logic [AddrW-1:0]      bus_addro,
  output logic [DataW-1:0]      bus_wdatao,
  input  logic                  bus_ready,
  input  logic [IdW-1:0]        bus_id,
  input  logic [DataW-1:0]      bus_rdata,
  input  logic                  bus_busy
);
  localparam axi3_size_t FullSize = axi3_size_t'($clog2(StrbW));
  state_t                r_state, w_next;
  logic [AxiIdW-1:0]     r_id;
  logic [AddrW-1:0]      r_addr, w_addr_nxt;
  logic [AXI3_LEN_W-1:0] r_len, r_cnt;
  axi3_bst_t             r_burst;
  logic                  r_err, r_last_wr;
  logic [DataW-1:0]      r_wdata, r_rdata;
  logic [StrbW-1:0]      r_strb;
  logic                  w_last, w_req, w_done, w_to, w_gen_err, w_wlast_err, w_adv, w_wait, w_unused;

  axi_burst_addr_gen #(.AddrW(AddrW)) u_addr_gen (
    .i_addr (r_addr),
    .i_burst(r_burst),
    .i_step (AddrW'(StrbW)),
    .o_addr (w_addr_nxt),
    .o_err  (w_gen_err)
  );

  assign w_last      = r_cnt == r_len;
  assign w_wait      = (r_state == WR_WAIT) || (r_state == RD_WAIT);
  assign w_req       = ((r_state == WR_REQ) || (r_state == RD_REQ)) && !bus_busy;
  assign w_wlast_err = (r_state == WR_DATA) && axi_wvalid && (axi_wlast != w_last);
  assign w_unused    = ^bus_id ^ (TimeoutCyc == 0);

`ifdef AXI2LBUS_SLAVE_TIMEOUT_EN
  logic [15:0] r_to;
  assign w_to = w_wait && !bus_ready && (r_to == 16'(TimeoutCyc));
  // wait-cycle counter, restarted by every lbus request
  always_ff @(posedge clk) r_to <= (reset || w_req) ? '0 : w_wait ? r_to + 16'd1 : r_to;
`else
  assign w_to = 1'b0;
`endif
  assign w_done = bus_ready || w_to;

  // next state, AXI address handshakes and beat-complete strobe
  always_comb begin
    w_next       = r_state;
    axi_awreadyo = 1'b0;
    axi_arreadyo = 1'b0;
    w_adv        = 1'b0;
    case (r_state)
      IDLE: begin
        axi_awreadyo = axi_awvalid && (!axi_arvalid || !r_last_wr);
        axi_arreadyo = axi_arvalid && !axi_awreadyo;
        w_next       = axi_awreadyo ? WR_DATA : axi_arreadyo ? RD_REQ : IDLE;
      end
      WR_DATA: if (axi_wvalid) begin
        w_adv  = axi_wstrb == '0;
        w_next = (axi_wstrb != '0) ? WR_REQ : w_last ? WR_RESP : WR_DATA;
      end
      WR_REQ:  w_next = bus_busy ? WR_REQ : WR_WAIT;
      WR_WAIT: if (w_done) begin
        w_adv  = 1'b1;
        w_next = w_last ? WR_RESP : WR_DATA;
      end
      WR_RESP: w_next = axi_bready ? IDLE : WR_RESP;
      RD_REQ:  w_next = bus_busy ? RD_REQ : RD_WAIT;
      RD_WAIT: w_next = w_done ? RD_DATA : RD_WAIT;
      RD_DATA: if (axi_rready) begin
        w_adv  = 1'b1;
        w_next = w_last ? IDLE : RD_REQ;
      end
      default: w_next = IDLE;
    endcase
  end

  assign axi_wreadyo = r_state == WR_DATA;
  assign axi_bvalido = r_state == WR_RESP;
  assign axi_bido    = r_id;
  assign axi_brespo  = r_err ? RESP_SLVERR : RESP_OKAY;
  assign axi_rvalido = r_state == RD_DATA;
  assign axi_rido    = r_id;
  assign axi_rdatao  = r_rdata;
  assign axi_rrespo  = r_err ? RESP_SLVERR : RESP_OKAY;
  assign axi_rlasto  = axi_rvalido && w_last;
  assign bus_reqo    = w_req;
  assign bus_ido     = BusId;
  assign bus_strbo   = (r_state == WR_REQ) ? r_strb : '0;
  assign bus_addro   = r_addr;
  assign bus_wdatao  = r_wdata;

  // state, latched command, sticky error and beat datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= BST_FIXED;
      r_err     <= 1'b0;
      r_last_wr <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_next;
      if (axi_awreadyo || axi_arreadyo) begin
        r_id      <= axi_awreadyo ? axi_awid : axi_arid;
        r_addr    <= axi_awreadyo ? axi_awaddr : axi_araddr;
        r_len     <= axi_awreadyo ? axi_awlen : axi_arlen;
        r_burst   <= axi_awreadyo ? axi_awburst : axi_arburst;
        r_err     <= (axi_awreadyo ? axi_awsize : axi_arsize) != FullSize;
        r_cnt     <= '0;
        r_last_wr <= axi_awreadyo;
      end else if (r_state != IDLE) begin
        r_err <= r_err | w_gen_err | w_wlast_err | w_to;
        if (w_adv) begin
          r_cnt  <= r_cnt + 1'b1;
          r_addr <= w_addr_nxt;
        end
      end
      if ((r_state == WR_DATA) && axi_wvalid) begin
        r_wdata <= axi_wdata;
        r_strb  <= axi_wstrb;
      end
      if ((r_state == RD_WAIT) && w_done) r_rdata <= w_to ? '0 : bus_rdata;
    end
  end
endmodule

// File: tb/tb_axi2lbus_slave.sv
// tb_axi2lbus_slave: directed scoreboard bench for axi2lbus_slave
module tb_axi2lbus_slave;
  import axi2lbus_slave_pkg::*;
  typedef struct packed {logic [7:0] addr; logic [3:0] strb; logic [31:0] data;} req_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_t;

  logic clk = 0, reset = 1;
  logic [3:0] axi_awid = 0, axi_arid = 0, axi_bido, axi_rido;
  logic [7:0] axi_awaddr = 0, axi_araddr = 0, bus_addro;
  logic [3:0] axi_awlen = 0, axi_arlen = 0, axi_wstrb = 0, bus_strbo;
  axi3_size_t axi_awsize = 3'd2, axi_arsize = 3'd2;
  axi3_bst_t axi_awburst = BST_INCR, axi_arburst = BST_INCR;
  axi3_resp_t axi_brespo, axi_rrespo;
  logic axi_awvalid = 0, axi_awreadyo, axi_wlast = 0, axi_wvalid = 0, axi_wreadyo, axi_bvalido, axi_bready = 0;
  logic axi_arvalid = 0, axi_arreadyo, axi_rlasto, axi_rvalido, axi_rready = 0;
  logic [31:0] axi_wdata = 0, axi_rdatao, bus_wdatao, bus_rdata = 0, pend_d = 0;
  logic bus_reqo, bus_ready = 0, bus_busy = 0, tgt_en = 1, pend = 0;
  logic [1:0] bus_ido, bus_id = 0;
  req_t exp_req[$];
  rbeat_t exp_r[$];
  b_t exp_b[$];
  logic [31:0] rdq[$];
  int n_pass = 0, n_fail = 0, n_tot = 0, req_seen = 0;

  always #5 clk = ~clk;

  axi2lbus_slave dut (
    .clk(clk), .reset(reset),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awreadyo(axi_awreadyo),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wreadyo(axi_wreadyo), .axi_bido(axi_bido), .axi_brespo(axi_brespo), .axi_bvalido(axi_bvalido),
    .axi_bready(axi_bready), .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arreadyo(axi_arreadyo),
    .axi_rido(axi_rido), .axi_rdatao(axi_rdatao), .axi_rrespo(axi_rrespo), .axi_rlasto(axi_rlasto),
    .axi_rvalido(axi_rvalido), .axi_rready(axi_rready), .bus_reqo(bus_reqo), .bus_ido(bus_ido),
    .bus_strbo(bus_strbo), .bus_addro(bus_addro), .bus_wdatao(bus_wdatao), .bus_ready(bus_ready),
    .bus_id(bus_id), .bus_rdata(bus_rdata), .bus_busy(bus_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // lbus target: checks each request against the scoreboard and answers in the following cycle
  always @(negedge clk) begin
    req_t e;
    bus_ready = pend;
    bus_rdata = pend_d;
    pend = 0;
    if (!reset && bus_reqo) begin
      req_seen++;
      pend = tgt_en;
      chk("req_expected", 64'(exp_req.size() > 0), 1);
      if (exp_req.size() > 0) begin
        e = exp_req.pop_front();
        chk("req_addr", bus_addro, e.addr);
        chk("req_strb", bus_strbo, e.strb);
        chk("req_id", bus_ido, 0);
        if (e.strb != 0) chk("req_wdata", bus_wdatao, e.data);
      end
      if (bus_strbo == 0) pend_d = (rdq.size() > 0) ? rdq.pop_front() : 32'hBAD0BAD0;
    end
  end

  task automatic set_aw(input logic [3:0] id, input logic [7:0] a, input logic [3:0] l, input axi3_bst_t b, input axi3_size_t sz);
    axi_awid = id; axi_awaddr = a; axi_awlen = l; axi_awburst = b; axi_awsize = sz; axi_awvalid = 1;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [7:0] a, input logic [3:0] l, input axi3_bst_t b, input axi3_size_t sz);
    axi_arid = id; axi_araddr = a; axi_arlen = l; axi_arburst = b; axi_arsize = sz; axi_arvalid = 1;
  endtask

  task automatic hs_aw();
    int n = 0;
    @(negedge clk);
    while (!axi_awreadyo && n < 50) begin @(negedge clk); n++; end
    chk("aw_handshake", axi_awreadyo, 1);
    @(posedge clk); #1 axi_awvalid = 0;
  endtask

  task automatic hs_ar();
    int n = 0;
    @(negedge clk);
    while (!axi_arreadyo && n < 50) begin @(negedge clk); n++; end
    chk("ar_handshake", axi_arreadyo, 1);
    @(posedge clk); #1 axi_arvalid = 0;
  endtask

  task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    axi_wdata = d; axi_wstrb = s; axi_wlast = l; axi_wvalid = 1;
    @(negedge clk);
    while (!axi_wreadyo && n < 50) begin @(negedge clk); n++; end
    chk("w_handshake", axi_wreadyo, 1);
    @(posedge clk); #1 axi_wvalid = 0;
  endtask

  task automatic bchk();
    int n = 0;
    b_t e;
    @(negedge clk);
    while (!axi_bvalido && n < 50) begin @(negedge clk); n++; end
    chk("b_valid", axi_bvalido, 1);
    e = exp_b.pop_front();
    chk("b_id", axi_bido, e.id);
    chk("b_resp", axi_brespo, e.resp);
    axi_bready = 1;
    @(posedge clk); #1 axi_bready = 0;
  endtask

  task automatic rchk(input int stall);
    int n = 0;
    rbeat_t e;
    @(negedge clk);
    while (!axi_rvalido && n < 400) begin @(negedge clk); n++; end
    chk("r_valid", axi_rvalido, 1);
    e = exp_r.pop_front();
    chk("r_id", axi_rido, e.id);
    chk("r_data", axi_rdatao, e.data);
    chk("r_resp", axi_rrespo, e.resp);
    chk("r_last", axi_rlasto, e.last);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk("r_hold_valid", axi_rvalido, 1);
      chk("r_hold_data", axi_rdatao, e.data);
      chk("r_hold_last", axi_rlasto, e.last);
    end
    axi_rready = 1;
    @(posedge clk); #1 axi_rready = 0;
  endtask

  initial begin
    #500000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_req, base;
    logic seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readys", {axi_awreadyo, axi_arreadyo, axi_wreadyo}, 0);
    chk("rst_valids", {axi_bvalido, axi_rvalido, axi_rlasto, bus_reqo}, 0);
    chk("rst_data", {axi_rdatao, bus_wdatao}, 0);
    chk("rst_misc", {bus_addro, bus_strbo, axi_bido, axi_rido, axi_brespo, axi_rrespo}, 0);
    @(posedge clk); #1 reset = 0;

    // both directions valid from reset: write, then read, then the waiting write
    exp_req.push_back(req_t'{8'h10, 4'hF, 32'hDEADBEEF});
    exp_b.push_back(b_t'{4'h3, RESP_OKAY});
    exp_req.push_back(req_t'{8'h40, 4'h0, 32'h0});
    rdq.push_back(32'h11111111);
    exp_r.push_back(rbeat_t'{4'h5, 32'h11111111, RESP_OKAY, 1'b1});
    exp_req.push_back(req_t'{8'h50, 4'hF, 32'hCAFEF00D});
    exp_b.push_back(b_t'{4'h6, RESP_OKAY});
    set_aw(4'h3, 8'h10, 4'd0, BST_INCR, 3'd2);
    set_ar(4'h5, 8'h40, 4'd0, BST_INCR, 3'd2);
    @(negedge clk);
    chk("rr0_awready", axi_awreadyo, 1);
    chk("rr0_arready", axi_arreadyo, 0);
    @(posedge clk); #1 axi_awvalid = 0;
    wbeat(32'hDEADBEEF, 4'hF, 1);
    bchk();
    set_aw(4'h6, 8'h50, 4'd0, BST_INCR, 3'd2);
    @(negedge clk);
    chk("rr1_arready", axi_arreadyo, 1);
    chk("rr1_awready", axi_awreadyo, 0);
    @(posedge clk); #1 axi_arvalid = 0;
    rchk(0);
    hs_aw();
    wbeat(32'hCAFEF00D, 4'hF, 1);
    bchk();

    // INCR read burst with rready stalls
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(req_t'{8'(8'h20 + 4 * i), 4'h0, 32'h0});
      rdq.push_back(32'(i + 1));
      exp_r.push_back(rbeat_t'{4'h9, 32'(i + 1), RESP_OKAY, i == 3});
    end
    set_ar(4'h9, 8'h20, 4'd3, BST_INCR, 3'd2);
    hs_ar();
    rchk(0); rchk(3); rchk(0); rchk(2);

    // AR handshake cycle counts as cycle 1; rvalid expected in cycle 4
    exp_req.push_back(req_t'{8'h30, 4'h0, 32'h0});
    rdq.push_back(32'h0BADCAFE);
    exp_r.push_back(rbeat_t'{4'h1, 32'h0BADCAFE, RESP_OKAY, 1'b1});
    set_ar(4'h1, 8'h30, 4'd0, BST_INCR, 3'd2);
    @(negedge clk);
    chk("lat_arready", axi_arreadyo, 1);
    lat = 1;
    @(posedge clk); #1 axi_arvalid = 0;
    while (!axi_rvalido && lat < 20) begin @(negedge clk); lat++; end
    chk("rd_latency", lat, 4);
    rchk(0);

    // bus_busy held for 5 cycles delays the request by exactly 5 cycles
    exp_req.push_back(req_t'{8'h34, 4'h0, 32'h0});
    rdq.push_back(32'h55AA55AA);
    exp_r.push_back(rbeat_t'{4'h2, 32'h55AA55AA, RESP_OKAY, 1'b1});
    set_ar(4'h2, 8'h34, 4'd0, BST_INCR, 3'd2);
    hs_ar();
    bus_busy = 1;
    busy_req = 0;
    repeat (5) begin @(negedge clk); busy_req += int'(bus_reqo); end
    @(posedge clk); #1 bus_busy = 0;
    @(negedge clk);
    chk("busy_no_req", busy_req, 0);
    chk("busy_req_after", bus_reqo, 1);
    rchk(0);

    // second beat with wstrb=0 produces no lbus access
    exp_req.push_back(req_t'{8'h60, 4'hF, 32'hA5A5A5A5});
    exp_b.push_back(b_t'{4'h7, RESP_OKAY});
    base = req_seen;
    set_aw(4'h7, 8'h60, 4'd1, BST_INCR, 3'd2);
    hs_aw();
    wbeat(32'hA5A5A5A5, 4'hF, 0);
    wbeat(32'h12345678, 4'h0, 1);
    bchk();
    chk("strb0_one_req", req_seen - base, 1);

    // early wlast on beat 0: both beats still run, response SLVERR
    exp_req.push_back(req_t'{8'h70, 4'h3, 32'h00001111});
    exp_req.push_back(req_t'{8'h74, 4'hC, 32'h22220000});
    exp_b.push_back(b_t'{4'h8, RESP_SLVERR});
    set_aw(4'h8, 8'h70, 4'd1, BST_INCR, 3'd2);
    hs_aw();
    wbeat(32'h00001111, 4'h3, 1);
    wbeat(32'h22220000, 4'hC, 1);
    bchk();

    // FIXED read holds the address
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(req_t'{8'hFC, 4'h0, 32'h0});
      rdq.push_back(32'(i + 7));
      exp_r.push_back(rbeat_t'{4'h4, 32'(i + 7), RESP_OKAY, i == 2});
    end
    set_ar(4'h4, 8'hFC, 4'd2, BST_FIXED, 3'd2);
    hs_ar();
    rchk(0); rchk(1); rchk(0);

    // INCR wraps from 0xFC to 0x00
    exp_req.push_back(req_t'{8'hFC, 4'h0, 32'h0});
    exp_req.push_back(req_t'{8'h00, 4'h0, 32'h0});
    rdq.push_back(32'hAAAA0001);
    rdq.push_back(32'hAAAA0002);
    exp_r.push_back(rbeat_t'{4'hB, 32'hAAAA0001, RESP_OKAY, 1'b0});
    exp_r.push_back(rbeat_t'{4'hB, 32'hAAAA0002, RESP_OKAY, 1'b1});
    set_ar(4'hB, 8'hFC, 4'd1, BST_INCR, 3'd2);
    hs_ar();
    rchk(0); rchk(0);

    // WRAP read runs as INCR with SLVERR; narrow write runs full width with SLVERR
    exp_req.push_back(req_t'{8'h90, 4'h0, 32'h0});
    exp_req.push_back(req_t'{8'h94, 4'h0, 32'h0});
    rdq.push_back(32'h00000090);
    rdq.push_back(32'h00000094);
    exp_r.push_back(rbeat_t'{4'hC, 32'h00000090, RESP_SLVERR, 1'b0});
    exp_r.push_back(rbeat_t'{4'hC, 32'h00000094, RESP_SLVERR, 1'b1});
    set_ar(4'hC, 8'h90, 4'd1, BST_WRAP, 3'd2);
    hs_ar();
    rchk(0); rchk(0);
    exp_req.push_back(req_t'{8'hA0, 4'hF, 32'h0F0F0F0F});
    exp_b.push_back(b_t'{4'hD, RESP_SLVERR});
    set_aw(4'hD, 8'hA0, 4'd0, BST_INCR, 3'd1);
    hs_aw();
    wbeat(32'h0F0F0F0F, 4'hF, 1);
    bchk();

    // target never answers
    tgt_en = 0;
    exp_req.push_back(req_t'{8'h80, 4'h0, 32'h0});
    set_ar(4'hA, 8'h80, 4'd0, BST_INCR, 3'd2);
    hs_ar();
`ifdef AXI2LBUS_SLAVE_TIMEOUT_EN
    exp_r.push_back(rbeat_t'{4'hA, 32'h0, RESP_SLVERR, 1'b1});
    rchk(0);
`else
    seen = 0;
    repeat (300) begin @(negedge clk); seen |= axi_rvalido; end
    chk("no_timeout_rvalid", seen, 0);
`endif
    chk("req_queue_drained", exp_req.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
